ide_data_fifo: RTL and testbench

IDE_DATA_FIFO -- requirements
Module: ide_data_fifo

---
 rtl/ide_pkg.sv | 12 +
 rtl/ide_dpram.sv | 39 +++
 rtl/ide_data_fifo.sv | 152 +++++++++++++++
 tb/tb_ide_data_fifo.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ide_pkg.sv
// Shared IDE data-path constants: word size and sector depth.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ide_pkg;

    // One ATA data-register word is two bytes.
    localparam int IDE_WORD_BYTES       = 2;
    // One 512-byte sector holds 256 such words.
    localparam int IDE_SECTOR_WORDS     = 256;
    localparam int IDE_SECTOR_ADDR_BITS = $clog2(IDE_SECTOR_WORDS);

endpackage

// File: rtl/ide_dpram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
// Latency: read data appears the cycle after re_i, and holds until the next re_i.
// Backpressure: none; the owner guards against reading and writing the same word.
//
// Ports: clk_i clock; we_i/waddr_i/wdata_i write port;
//        re_i/raddr_i read request; rdata_o registered read word.
module ide_dpram #(
    parameter int ADDR_BITS = 8,
    parameter int W         = 16
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] waddr_i,
    input  logic [W-1:0]         wdata_i,
    input  logic                 re_i,
    input  logic [ADDR_BITS-1:0] raddr_i,
    output logic [W-1:0]         rdata_o
);

    logic [W-1:0] mem_q [2**ADDR_BITS];
    logic [W-1:0] rdata_q;

    // No reset on the array or the read register, so the tools can map
    // both into a block RAM with its output register.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ide_data_fifo.sv
// IDE sector data FIFO: synchronous FIFO with level, status and sticky error flags.
// Latency: popped word on rd_data with rd_valid one cycle after an accepted rd_en.
// Backpressure: push dropped when full (sets overflow), pop ignored when empty (sets underflow).
//
// Ports: clk clock; rst synchronous active-high reset; flush synchronous empty;
//        wr_en/wr_data push; rd_en pop; rd_data/rd_valid registered pop result;
//        level word count; empty/full/almost_full status; overflow/underflow sticky errors.
// Optional: define IDE_DATA_FIFO_SWAP_EN to add input swap, which byte-reverses
//        the word popped in the same cycle.
module ide_data_fifo
    import ide_pkg::*;
#(
    parameter int ADDR_BITS  = IDE_SECTOR_ADDR_BITS,
    parameter int DATA_BYTES = IDE_WORD_BYTES,
    parameter int AF_LEVEL   = (2**ADDR_BITS) - 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    wr_en,
    input  logic [8*DATA_BYTES-1:0] wr_data,
    input  logic                    rd_en,
`ifdef IDE_DATA_FIFO_SWAP_EN
    input  logic                    swap,
`endif
    output logic [8*DATA_BYTES-1:0] rd_data,
    output logic                    rd_valid,
    output logic [ADDR_BITS:0]      level,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_full,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int                 W        = 8 * DATA_BYTES;
    localparam int                 PW       = ADDR_BITS + 1;
    localparam logic [ADDR_BITS:0] AF_THR   = PW'(AF_LEVEL);
    localparam logic [ADDR_BITS:0] MSB_ONLY = {1'b1, {ADDR_BITS{1'b0}}};

    logic [ADDR_BITS:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS:0] level_q, level_d;
    logic               empty_q, empty_d;
    logic               full_q, full_d;
    logic               af_q, af_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               rd_valid_q;
    // Set by the first pop after reset; until then rd_data reads as zero,
    // because the RAM read register itself cannot be reset.
    logic               has_data_q, has_data_d;
    logic               push_ok, pop_ok;
    logic [W-1:0]       ram_rdata;
    logic [W-1:0]       rd_word;

    always_comb begin
        push_ok  = wr_en & ~full_q  & ~flush;
        pop_ok   = rd_en & ~empty_q & ~flush;

        wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(push_ok);
        rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(pop_ok);

        // Flags come from the next-state pointers so they change in the
        // same cycle as the pointers they describe.
        level_d  = wr_ptr_d - rd_ptr_d;
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = ((wr_ptr_d ^ rd_ptr_d) == MSB_ONLY);
        af_d     = (level_d >= AF_THR);

        // Errors look at the current flags only, so an accepted pop does not
        // excuse a push into a full FIFO (and vice versa for underflow).
        ovf_d      = flush ? 1'b0 : (ovf_q | (wr_en & full_q));
        unf_d      = flush ? 1'b0 : (unf_q | (rd_en & empty_q));
        has_data_d = has_data_q | pop_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            af_q       <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            has_data_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            af_q       <= af_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            rd_valid_q <= pop_ok;
            has_data_q <= has_data_d;
        end
    end

    // A pop only happens when not empty, so the read address never equals
    // an address being written in the same cycle.
    ide_dpram #(
        .ADDR_BITS (ADDR_BITS),
        .W         (W)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (push_ok),
        .waddr_i (wr_ptr_q[ADDR_BITS-1:0]),
        .wdata_i (wr_data),
        .re_i    (pop_ok),
        .raddr_i (rd_ptr_q[ADDR_BITS-1:0]),
        .rdata_o (ram_rdata)
    );

`ifdef IDE_DATA_FIFO_SWAP_EN
    // swap is captured alongside the pop it belongs to and held with the word.
    logic swap_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            swap_q <= 1'b0;
        end else if (pop_ok) begin
            swap_q <= swap;
        end
    end

    always_comb begin
        rd_word = ram_rdata;
        if (swap_q) begin
            for (int i = 0; i < DATA_BYTES; i++) begin
                rd_word[8*i +: 8] = ram_rdata[8*(DATA_BYTES-1-i) +: 8];
            end
        end
    end
`else
    assign rd_word = ram_rdata;
`endif

    assign rd_data     = has_data_q ? rd_word : '0;
    assign rd_valid    = rd_valid_q;
    assign level       = level_q;
    assign empty       = empty_q;
    assign full        = full_q;
    assign almost_full = af_q;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

endmodule

// File: tb/tb_ide_data_fifo.sv
// Testbench for ide_data_fifo at default parameters.
// Latency: n/a.
// Backpressure: n/a.
module tb_ide_data_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic        swap_v = 1'b0;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic [8:0]  level;
    logic        empty, full, almost_full, overflow, underflow;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [15:0] mq[$];     // words stored in the FIFO
    logic [15:0] exq[$];    // words expected on rd_data, in order
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;
    logic        m_vld = 1'b0;

    always #5 clk = ~clk;

    ide_data_fifo dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
`ifdef IDE_DATA_FIFO_SWAP_EN
        .swap        (swap_v),
`endif
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .level       (level),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every rd_valid pulse must match the next queued word.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (exq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_valid_unexpected act=1 exp=0 t=%0t", $time);
            end else begin
                chk("rd_data", {16'h0, rd_data}, {16'h0, exq.pop_front()});
            end
        end
    end

    // One clock cycle: drive inputs, update model at the edge, check flags after.
    task automatic cyc(input logic w, input logic [15:0] d, input logic r,
                       input logic f, input logic rs);
        bit          push_ok, pop_ok;
        logic [15:0] pw;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        flush   = f;
        rst     = rs;
        push_ok = w && !rs && !f && (mq.size() < 256);
        pop_ok  = r && !rs && !f && (mq.size() > 0);
        @(posedge clk);
        if (rs) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_vld = 1'b0;
        end else if (f) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_vld = 1'b0;
        end else begin
            if (w && mq.size() == 256) m_ovf = 1'b1;
            if (r && mq.size() == 0)   m_unf = 1'b1;
            if (pop_ok) begin
                pw = mq.pop_front();
`ifdef IDE_DATA_FIFO_SWAP_EN
                if (swap_v) pw = {pw[7:0], pw[15:8]};
`endif
                exq.push_back(pw);
            end
            if (push_ok) mq.push_back(d);
            m_vld = pop_ok;
        end
        #1;
        chk("level",       {23'h0, level},       mq.size());
        chk("empty",       {31'h0, empty},       {31'h0, mq.size() == 0});
        chk("full",        {31'h0, full},        {31'h0, mq.size() == 256});
        chk("almost_full", {31'h0, almost_full}, {31'h0, mq.size() >= 240});
        chk("overflow",    {31'h0, overflow},    {31'h0, m_ovf});
        chk("underflow",   {31'h0, underflow},   {31'h0, m_unf});
        chk("rd_valid",    {31'h0, rd_valid},    {31'h0, m_vld});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        cyc(0, 16'h0, 0, 0, 1);
        cyc(0, 16'h0, 0, 0, 1);
        chk("reset_rd_data", {16'h0, rd_data}, 32'h0);
        chk("reset_empty",   {31'h0, empty},   32'h1);

        // Two pushes, two pops
        cyc(1, 16'h1234, 0, 0, 0);
        cyc(1, 16'hABCD, 0, 0, 0);
        cyc(0, 16'h0, 1, 0, 0);
        cyc(0, 16'h0, 1, 0, 0);
        cyc(0, 16'h0, 0, 0, 0);
        chk("basic_empty", {31'h0, empty}, 32'h1);
        chk("basic_level", {23'h0, level}, 32'h0);
        chk("basic_last",  {16'h0, rd_data}, 32'hABCD);

        // Fill to 256, overflow on the 257th, then push into full with a pop
        for (int i = 0; i < 256; i++) cyc(1, 16'h1000 + 16'(i), 0, 0, 0);
        chk("fill_full",  {31'h0, full},        32'h1);
        chk("fill_level", {23'h0, level},       32'h100);
        chk("fill_af",    {31'h0, almost_full}, 32'h1);
        cyc(1, 16'hDEAD, 0, 0, 0);
        chk("fill_ovf",   {31'h0, overflow},    32'h1);
        cyc(1, 16'hBEEF, 1, 0, 0);
        chk("full_pushpop_level", {23'h0, level}, 32'hFF);
        for (int i = 0; i < 255; i++) cyc(0, 16'h0, 1, 0, 0);
        cyc(0, 16'h0, 0, 0, 0);
        chk("drain_last", {16'h0, rd_data}, 32'h10FF);

        // Steady push+pop at level 5, pointers wrap
        for (int i = 0; i < 5; i++) cyc(1, 16'h3000 + 16'(i), 0, 0, 0);
        for (int i = 0; i < 300; i++) cyc(1, 16'h2000 + 16'(i), 1, 0, 0);
        chk("stream_level", {23'h0, level}, 32'h5);
        for (int i = 0; i < 5; i++) cyc(0, 16'h0, 1, 0, 0);
        cyc(0, 16'h0, 0, 0, 0);
        chk("stream_last", {16'h0, rd_data}, 32'h212B);

        // Pop on empty with a simultaneous push
        cyc(1, 16'h5555, 1, 0, 0);
        chk("unf_flag",  {31'h0, underflow}, 32'h1);
        chk("unf_level", {23'h0, level},     32'h1);
        cyc(0, 16'h0, 0, 0, 0);
        chk("unf_novalid", {31'h0, rd_valid}, 32'h0);

        // Flush at level 100 with push and pop asserted
        for (int i = 0; i < 99; i++) cyc(1, 16'h4000 + 16'(i), 0, 0, 0);
        chk("pre_flush_level", {23'h0, level}, 32'h64);
        cyc(1, 16'h7777, 1, 1, 0);
        chk("flush_level",   {23'h0, level},     32'h0);
        chk("flush_empty",   {31'h0, empty},     32'h1);
        chk("flush_ovf",     {31'h0, overflow},  32'h0);
        chk("flush_unf",     {31'h0, underflow}, 32'h0);
        chk("flush_rd_data", {16'h0, rd_data},   32'h212B);

        // Reset in the middle of a push+pop burst
        for (int i = 0; i < 4; i++) cyc(1, 16'h6000 + 16'(i), 0, 0, 0);
        cyc(1, 16'h6004, 1, 0, 0);
        cyc(1, 16'h6005, 1, 0, 1);
        chk("rst_rd_data", {16'h0, rd_data},     32'h0);
        chk("rst_level",   {23'h0, level},       32'h0);
        chk("rst_empty",   {31'h0, empty},       32'h1);
        chk("rst_valid",   {31'h0, rd_valid},    32'h0);
        chk("rst_af",      {31'h0, almost_full}, 32'h0);

        // Byte swap (only byte-reversed when the option is built in)
        swap_v = 1'b1;
        cyc(1, 16'h1234, 0, 0, 0);
        cyc(0, 16'h0, 1, 0, 0);
        swap_v = 1'b0;
        cyc(0, 16'h0, 0, 0, 0);
`ifdef IDE_DATA_FIFO_SWAP_EN
        chk("swap_data", {16'h0, rd_data}, 32'h3412);
`else
        chk("swap_data", {16'h0, rd_data}, 32'h1234);
`endif

        cyc(0, 16'h0, 0, 0, 0);
        chk("scoreboard_drained", exq.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
